// File: rtl/mac_pipe_pkg.sv
// Shared MAC pipeline constants and requantization helper.
// Used by the MAC wrapper, the pooling stage and the test pattern.
package mac_pipe_pkg;

  localparam int OFM_W   = 10;
  localparam int IFM_W   = 4;
  localparam int IFM_MAX = 15;

  function automatic logic [IFM_W-1:0] sat_shift(
    input logic [OFM_W-1:0] ofm,
    input int unsigned      shift
  );
    logic [OFM_W-1:0] s;
    s = ofm >> shift;
    if (s > OFM_W'(IFM_MAX)) return IFM_W'(IFM_MAX);
    return s[IFM_W-1:0];
  endfunction

endpackage

// File: rtl/ofm_pool_quant_if.sv
// MAC result input stream and requantized IFM output stream.
// slave = pooling stage side, master = producer/consumer side.
interface ofm_pool_quant_if;
  import mac_pipe_pkg::*;

  logic             in_valid;
  logic [OFM_W-1:0] in_OFM;
  logic             out_ready;
  logic             out_valid;
  logic [IFM_W-1:0] out_IFM;

  modport slave (
    input  in_valid,
    input  in_OFM,
    input  out_ready,
    output out_valid,
    output out_IFM
  );

  modport master (
    output in_valid,
    output in_OFM,
    output out_ready,
    input  out_valid,
    input  out_IFM
  );

endinterface

// File: rtl/ifm_fifo.sv
// Small synchronous FIFO, pointer plus occupancy count.
// Accepts a push while full when a pop happens in the same cycle.
module ifm_fifo
  import mac_pipe_pkg::*;
#(
  parameter int W     = IFM_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  logic w_pop;
  logic w_push;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign dout   = r_mem[r_rd];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // storage, pointers and occupancy; clear drops all entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop) r_cnt <= r_cnt + (AW+1)'(1);
      if (!w_push && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ofm_pool_quant.sv
// Max-pools MAC results in windows, requantizes to 4 bits, buffers output.
// The MAC is never stalled; a full FIFO drops the result and flags it.
module ofm_pool_quant
  import mac_pipe_pkg::*;
#(
  parameter int POOL_N     = 4,
  parameter int SHIFT      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  ofm_pool_quant_if.slave         bus,
  output logic [$clog2(POOL_N):0] win_cnt,
  output logic                    drop_err
);

  localparam int CW = $clog2(POOL_N) + 1;

  logic [CW-1:0]    r_win_cnt;
  logic [OFM_W-1:0] r_run_max;
  logic             r_drop;

  logic             w_last;
  logic [OFM_W-1:0] w_cand;
  logic [IFM_W-1:0] w_q;
  logic             w_close;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_last  = (r_win_cnt == CW'(POOL_N - 1));
  assign w_cand  = (r_win_cnt == '0) ? bus.in_OFM :
                   (bus.in_OFM > r_run_max) ? bus.in_OFM : r_run_max;
  assign w_q     = sat_shift(w_cand, SHIFT);
  assign w_close = bus.in_valid && !flush && w_last;
  assign w_pop   = !w_empty && bus.out_ready;

  assign bus.out_valid = !w_empty;
  assign win_cnt       = r_win_cnt;
  assign drop_err      = r_drop;

  // window counter and running max; flush abandons the partial window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt <= '0;
      r_run_max <= '0;
    end else if (flush) begin
      r_win_cnt <= '0;
      r_run_max <= '0;
    end else if (bus.in_valid) begin
      if (w_last) begin
        r_win_cnt <= '0;
      end else begin
        r_run_max <= w_cand;
        r_win_cnt <= r_win_cnt + CW'(1);
      end
    end
  end

  // sticky overrun flag, only cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else if (w_close && w_full && !w_pop) begin
      r_drop <= 1'b1;
    end
  end

  ifm_fifo #(
    .W     (IFM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (w_close),
    .pop   (bus.out_ready),
    .din   (w_q),
    .dout  (bus.out_IFM),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

// File: tb/tb_ofm_pool_quant.sv
// Directed bench for ofm_pool_quant.
// u0 uses default parameters, u1 uses SHIFT=4.
module tb_ofm_pool_quant;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush0 = 1'b0;
  logic flush1 = 1'b0;
  logic [2:0] wc0;
  logic [2:0] wc1;
  logic de0;
  logic de1;

  int n_pass = 0;
  int n_total = 0;

  ofm_pool_quant_if b0 ();
  ofm_pool_quant_if b1 ();

  ofm_pool_quant #(.POOL_N(4), .SHIFT(6), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0),
    .bus(b0), .win_cnt(wc0), .drop_err(de0)
  );

  ofm_pool_quant #(.POOL_N(4), .SHIFT(4), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1),
    .bus(b1), .win_cnt(wc1), .drop_err(de1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step0(input bit v, input logic [9:0] d);
    b0.in_valid = v;
    b0.in_OFM = d;
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
  endtask

  task automatic step1(input bit v, input logic [9:0] d);
    b1.in_valid = v;
    b1.in_OFM = d;
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    n_total++; if (b0.out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b exp 0", b0.out_valid); else n_pass++;
    n_total++; if (b0.out_IFM !== 4'd0) $display("FAIL rst_out_IFM got %0d exp 0", b0.out_IFM); else n_pass++;
    n_total++; if (wc0 !== 3'd0) $display("FAIL rst_win_cnt got %0d exp 0", wc0); else n_pass++;
    n_total++; if (de0 !== 1'b0) $display("FAIL rst_drop_err got %0b exp 0", de0); else n_pass++;
  endtask

  task automatic test_basic;
    logic [9:0] s [4] = '{10'd100, 10'd900, 10'd50, 10'd300};
    logic [2:0] w [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    b0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step0(1'b1, s[i]);
      n_total++; if (wc0 !== w[i]) $display("FAIL basic_win_cnt[%0d] got %0d exp %0d", i, wc0, w[i]); else n_pass++;
    end
    n_total++; if (b0.out_valid !== 1'b1) $display("FAIL basic_valid got %0b exp 1", b0.out_valid); else n_pass++;
    n_total++; if (b0.out_IFM !== 4'd14) $display("FAIL basic_ifm got %0d exp 14", b0.out_IFM); else n_pass++;
    step0(1'b0, 10'd0);
    n_total++; if (b0.out_valid !== 1'b0) $display("FAIL basic_pulse got %0b exp 0", b0.out_valid); else n_pass++;
  endtask

  task automatic test_shift;
    b1.out_ready = 1'b1;
    step1(1'b1, 10'd512);
    step1(1'b1, 10'd3);
    step1(1'b1, 10'd0);
    step1(1'b1, 10'd7);
    n_total++; if (b1.out_valid !== 1'b1) $display("FAIL shift_sat_valid got %0b exp 1", b1.out_valid); else n_pass++;
    n_total++; if (b1.out_IFM !== 4'd15) $display("FAIL shift_sat_ifm got %0d exp 15", b1.out_IFM); else n_pass++;
    step1(1'b1, 10'd0);
    step1(1'b1, 10'd0);
    step1(1'b1, 10'd16);
    step1(1'b1, 10'd15);
    n_total++; if (b1.out_valid !== 1'b1) $display("FAIL shift_one_valid got %0b exp 1", b1.out_valid); else n_pass++;
    n_total++; if (b1.out_IFM !== 4'd1) $display("FAIL shift_one_ifm got %0d exp 1", b1.out_IFM); else n_pass++;
    step1(1'b0, 10'd0);
    n_total++; if (b1.out_valid !== 1'b0) $display("FAIL shift_drain got %0b exp 0", b1.out_valid); else n_pass++;
  endtask

  task automatic test_full_pop;
    logic [3:0] exp_q [4] = '{4'd2, 4'd3, 4'd4, 4'd5};
    int pops;
    b0.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      for (int j = 0; j < 4; j++) step0(1'b1, 10'(k * 64));
    n_total++; if (b0.out_IFM !== 4'd1) $display("FAIL fp_head got %0d exp 1", b0.out_IFM); else n_pass++;
    for (int j = 0; j < 3; j++) step0(1'b1, 10'd320);
    b0.out_ready = 1'b1;
    step0(1'b1, 10'd320);
    n_total++; if (de0 !== 1'b0) $display("FAIL fp_drop got %0b exp 0", de0); else n_pass++;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      if (!b0.out_valid) break;
      if (pops < 4) begin
        n_total++; if (b0.out_IFM !== exp_q[pops]) $display("FAIL fp_pop[%0d] got %0d exp %0d", pops, b0.out_IFM, exp_q[pops]); else n_pass++;
      end
      pops++;
      step0(1'b0, 10'd0);
    end
    n_total++; if (pops !== 4) $display("FAIL fp_occupancy got %0d exp 4", pops); else n_pass++;
  endtask

  task automatic test_overflow;
    int pops;
    b0.out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step0(1'b1, 10'd1023);
      if (i == 16) begin
        n_total++; if (de0 !== 1'b0) $display("FAIL ov_drop_early got %0b exp 0", de0); else n_pass++;
      end
    end
    n_total++; if (de0 !== 1'b1) $display("FAIL ov_drop got %0b exp 1", de0); else n_pass++;
    n_total++; if (b0.out_valid !== 1'b1) $display("FAIL ov_valid got %0b exp 1", b0.out_valid); else n_pass++;
    b0.out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      if (!b0.out_valid) break;
      n_total++; if (b0.out_IFM !== 4'd15) $display("FAIL ov_pop[%0d] got %0d exp 15", pops, b0.out_IFM); else n_pass++;
      pops++;
      step0(1'b0, 10'd0);
    end
    n_total++; if (pops !== 4) $display("FAIL ov_pops got %0d exp 4", pops); else n_pass++;
    n_total++; if (b0.out_valid !== 1'b0) $display("FAIL ov_empty got %0b exp 0", b0.out_valid); else n_pass++;
  endtask

  task automatic test_rst_mid;
    b0.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step0(1'b1, 10'd1023);
    n_total++; if (wc0 !== 3'd2) $display("FAIL rm_pre_cnt got %0d exp 2", wc0); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (b0.out_valid !== 1'b0) $display("FAIL rm_valid got %0b exp 0", b0.out_valid); else n_pass++;
    n_total++; if (wc0 !== 3'd0) $display("FAIL rm_cnt got %0d exp 0", wc0); else n_pass++;
    n_total++; if (de0 !== 1'b0) $display("FAIL rm_drop got %0b exp 0", de0); else n_pass++;
    #2;
    rst_n = 1'b1;
    b0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step0(1'b1, 10'd64);
    n_total++; if (b0.out_valid !== 1'b1) $display("FAIL rm_post_valid got %0b exp 1", b0.out_valid); else n_pass++;
    n_total++; if (b0.out_IFM !== 4'd1) $display("FAIL rm_post_ifm got %0d exp 1", b0.out_IFM); else n_pass++;
    step0(1'b0, 10'd0);
  endtask

  task automatic test_gaps;
    b0.out_ready = 1'b1;
    step0(1'b1, 10'd64);
    step0(1'b0, 10'd0);
    step0(1'b0, 10'd0);
    n_total++; if (wc0 !== 3'd1) $display("FAIL gap_cnt got %0d exp 1", wc0); else n_pass++;
    step0(1'b1, 10'd128);
    step0(1'b1, 10'd192);
    step0(1'b0, 10'd0);
    n_total++; if (b0.out_valid !== 1'b0) $display("FAIL gap_early got %0b exp 0", b0.out_valid); else n_pass++;
    step0(1'b1, 10'd640);
    n_total++; if (b0.out_valid !== 1'b1) $display("FAIL gap_valid got %0b exp 1", b0.out_valid); else n_pass++;
    n_total++; if (b0.out_IFM !== 4'd10) $display("FAIL gap_ifm got %0d exp 10", b0.out_IFM); else n_pass++;
    step0(1'b0, 10'd0);
  endtask

  task automatic test_flush;
    b0.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step0(1'b1, 10'd1000);
    n_total++; if (wc0 !== 3'd3) $display("FAIL fl_pre_cnt got %0d exp 3", wc0); else n_pass++;
    flush0 = 1'b1;
    step0(1'b1, 10'd1000);
    flush0 = 1'b0;
    n_total++; if (wc0 !== 3'd0) $display("FAIL fl_cnt got %0d exp 0", wc0); else n_pass++;
    n_total++; if (b0.out_valid !== 1'b0) $display("FAIL fl_valid got %0b exp 0", b0.out_valid); else n_pass++;
    for (int i = 0; i < 3; i++) step0(1'b1, 10'd6);
    n_total++; if (b0.out_valid !== 1'b0) $display("FAIL fl_partial got %0b exp 0", b0.out_valid); else n_pass++;
    step0(1'b1, 10'd70);
    n_total++; if (b0.out_valid !== 1'b1) $display("FAIL fl_out_valid got %0b exp 1", b0.out_valid); else n_pass++;
    n_total++; if (b0.out_IFM !== 4'd1) $display("FAIL fl_ifm got %0d exp 1", b0.out_IFM); else n_pass++;
    n_total++; if (de0 !== 1'b0) $display("FAIL fl_drop got %0b exp 0", de0); else n_pass++;
  endtask

  initial begin
    b0.in_valid = 1'b0;
    b0.in_OFM = '0;
    b0.out_ready = 1'b0;
    b1.in_valid = 1'b0;
    b1.in_OFM = '0;
    b1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset;
    test_basic;
    test_shift;
    test_full_pop;
    test_overflow;
    test_rst_mid;
    test_gaps;
    test_flush;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
